// File: rtl/gp_pkg.sv
// Shared primitive-RAM package: record size, writer state encoding
// and the word type seen by the RAM, the writer and the raster reader.
package gp_pkg;
  localparam int unsigned REC_WORDS = 4;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FULL,
    ZFILL
  } state_e;
endpackage

// File: rtl/prim_ram_writer_if.sv
// Valid/ready word stream feeding the primitive RAM writer.
// The master drives words and the writer (slave) answers with ready.
interface prim_ram_writer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/prim_ram_writer_rec_addr_gen.sv
// Record pointer, word index, record count and fullness tracking
// for the primitive RAM writer.
module rec_addr_gen #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  abort_i,
  input  logic                  step_i,
  input  logic                  commit_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH-1:0] base_o,
  output logic                  last_o,
  output logic                  wrap_o,
  output logic [ADDR_WIDTH-2:0] count_o,
  output logic                  full_o
);
  import gp_pkg::*;

  localparam logic [ADDR_WIDTH:0] TOP_W =
    (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - 1);

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-2:0] cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic [ADDR_WIDTH:0]   nxt;

  assign nxt     = {1'b0, base_q} + (ADDR_WIDTH+1)'(REC_WORDS);
  // the next record would run past the last address: stop here
  assign wrap_o  = nxt > TOP_W;
  assign addr_o  = base_q + ADDR_WIDTH'(idx_q);
  assign base_o  = base_q;
  assign last_o  = idx_q == 2'd3;
  assign count_o = cnt_q;
  assign full_o  = full_q;

  always_comb begin
    base_d = base_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clr_i) begin
      base_d = '0;
      idx_d  = '0;
      cnt_d  = '0;
      full_d = 1'b0;
    end else begin
      if (abort_i) idx_d = '0;
      else if (step_i) idx_d = idx_q + 2'd1;
      if (commit_i) begin
        cnt_d = cnt_q + (ADDR_WIDTH-1)'(1);
        if (wrap_o) full_d = 1'b1;
        else base_d = nxt[ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      base_q <= base_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end
endmodule

// File: rtl/prim_ram_writer.sv
// Packs a word stream into 4-word records in the primitive RAM.
// Optional PRIM_RAM_WRITER_ZERO_FILL_EN zeroes the RAM on reset/clear.
module prim_ram_writer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int REC_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  prim_ram_writer_if.slave      in_if,
  input  logic                  in_abort,
  input  logic                  clear,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  prim_done,
  output logic [ADDR_WIDTH-1:0] prim_base,
  output logic [ADDR_WIDTH-2:0] prim_count,
  output logic                  full
);
  import gp_pkg::*;

  if (REC_WORDS != 4) begin : g_bad_rec
    $error("prim_ram_writer: REC_WORDS must be 4");
  end

  localparam bit FITS = ADDR_WIDTH >= 2;

  state_e                state_q;
  logic                  rdy_q, pend_q, we_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q, pbase_q;
  logic [DATA_WIDTH-1:0] data_q;
`ifdef PRIM_RAM_WRITER_ZERO_FILL_EN
  logic [ADDR_WIDTH-1:0] fill_q;
`endif

  logic                  clr, acc, abt, step, commit;
  logic                  last, wrap, ag_full;
  logic [ADDR_WIDTH-1:0] ag_addr, ag_base;

  assign clr    = clear && (state_q != IDLE) && FITS;
  assign acc    = in_if.in_valid && rdy_q && !clr;
  assign abt    = in_abort && !clr;
  assign step   = acc && !abt;
  assign commit = pend_q && !clr;

  rec_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ag (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .abort_i (abt),
    .step_i  (step),
    .commit_i(commit),
    .addr_o  (ag_addr),
    .base_o  (ag_base),
    .last_o  (last),
    .wrap_o  (wrap),
    .count_o (prim_count),
    .full_o  (ag_full)
  );

  assign in_if.in_ready = rdy_q;
  assign we        = we_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign prim_done = done_q;
  assign prim_base = pbase_q;
  assign full      = ag_full || (state_q == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      pbase_q <= '0;
`ifdef PRIM_RAM_WRITER_ZERO_FILL_EN
      fill_q  <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!FITS) begin
            state_q <= FULL;
          end else begin
`ifdef PRIM_RAM_WRITER_ZERO_FILL_EN
            state_q <= ZFILL;
            fill_q  <= '0;
`else
            state_q <= RUN;
            rdy_q   <= 1'b1;
`endif
          end
        end
        RUN, FULL: begin
          if (clr) begin
            pend_q <= 1'b0;
`ifdef PRIM_RAM_WRITER_ZERO_FILL_EN
            state_q <= ZFILL;
            rdy_q   <= 1'b0;
            fill_q  <= '0;
`else
            state_q <= RUN;
            rdy_q   <= 1'b1;
`endif
          end else begin
            if (step) begin
              we_q   <= 1'b1;
              addr_q <= ag_addr;
              data_q <= in_if.in_data;
              // hold off input for the one-cycle record commit
              if (last) begin
                rdy_q  <= 1'b0;
                pend_q <= 1'b1;
              end
            end
            if (commit) begin
              pend_q  <= 1'b0;
              done_q  <= 1'b1;
              pbase_q <= ag_base;
              rdy_q   <= !wrap;
              if (wrap) state_q <= FULL;
            end
          end
        end
        ZFILL: begin
`ifdef PRIM_RAM_WRITER_ZERO_FILL_EN
          if (clear) begin
            fill_q <= '0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= fill_q;
            data_q <= '0;
            fill_q <= fill_q + ADDR_WIDTH'(1);
            if (&fill_q) begin
              state_q <= RUN;
              rdy_q   <= 1'b1;
            end
          end
`else
          state_q <= IDLE;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prim_ram_writer.sv
// Directed bench for prim_ram_writer at ADDR_WIDTH=4, DATA_WIDTH=32.
// Define PRIM_RAM_WRITER_ZERO_FILL_EN to also exercise the zero fill.
module tb_prim_ram_writer;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_abort = 1'b0;
  logic          clear = 1'b0;
  logic          we, prim_done, full;
  logic [AW-1:0] wr_addr, prim_base;
  logic [AW-2:0] prim_count;
  logic [DW-1:0] wr_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [DW-1:0] ram [16];
  int wa[$];
  int wd[$];
  int wc[$];
  int db[$];
  int dn[$];
  int dc[$];

  prim_ram_writer_if #(.DATA_WIDTH(DW)) bus ();

  prim_ram_writer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .REC_WORDS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (bus.slave),
    .in_abort  (in_abort),
    .clear     (clear),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .prim_done (prim_done),
    .prim_base (prim_base),
    .prim_count(prim_count),
    .full      (full)
  );

  always #5 clk = ~clk;

  // RAM model and write/done log, sampled 2ns after each rising edge
  always @(posedge clk) begin
    #2;
    cyc++;
    if (we === 1'b1) begin
      ram[wr_addr] = wr_data;
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
      wc.push_back(cyc);
    end
    if (prim_done === 1'b1) begin
      db.push_back(int'(prim_base));
      dn.push_back(int'(prim_count));
      dc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete();
    db.delete(); dn.delete(); dc.delete();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, n);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    wait_ready();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    in_abort = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready();
    clear_logs();
  endtask

  task automatic check_zero(input string tag);
    tests++;
    if ({we, wr_addr, wr_data, prim_done, prim_base, prim_count, full, bus.in_ready} !== '0) begin
      fails++;
      $display("FAIL %s: we=%b addr=%0h data=%0h done=%b base=%0h cnt=%0d full=%b rdy=%b, want all 0",
               tag, we, wr_addr, wr_data, prim_done, prim_base, prim_count, full, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
`ifndef PRIM_RAM_WRITER_ZERO_FILL_EN
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_to_run: in_ready=%b want 1", bus.in_ready);
    end
`endif
  endtask

  task automatic test_record();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    repeat (4) @(negedge clk);
    tests++;
    if (wa.size() != 4) begin
      fails++;
      $display("FAIL rec_nwrites: got %0d want 4", wa.size());
    end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      tests++;
      if (wa[i] != i || wd[i] != 32'hA0 + i || wc[i] != wc[0] + i) begin
        fails++;
        $display("FAIL rec_write%0d: addr=%0d data=%0h cyc=+%0d want %0d %0h +%0d",
                 i, wa[i], wd[i], wc[i] - wc[0], i, 32'hA0 + i, i);
      end
    end
    tests++;
    if (db.size() != 1) begin
      fails++;
      $display("FAIL rec_ndone: got %0d want 1", db.size());
    end else begin
      tests++;
      if (db[0] != 0 || dn[0] != 1 || wc.size() != 4 || dc[0] != wc[3] + 1) begin
        fails++;
        $display("FAIL rec_done: base=%0d cnt=%0d got cyc %0d want base 0 cnt 1 one after last write",
                 db[0], dn[0], dc[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (ram[i] !== 32'hA0 + i) begin
        fails++;
        $display("FAIL rec_ram%0d: got %0h want %0h", i, ram[i], 32'hA0 + i);
      end
    end
  endtask

  task automatic test_abort();
    int exp_a[6] = '{0, 1, 0, 1, 2, 3};
    do_reset();
    push(32'hC0);
    push(32'hC1);
    in_abort = 1'b1;
    @(negedge clk);
    in_abort = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hB0 + i);
    repeat (4) @(negedge clk);
    tests++;
    if (wa.size() != 6) begin
      fails++;
      $display("FAIL abort_nwrites: got %0d want 6", wa.size());
    end
    for (int i = 0; i < 6 && i < wa.size(); i++) begin
      tests++;
      if (wa[i] != exp_a[i]) begin
        fails++;
        $display("FAIL abort_addr%0d: got %0d want %0d", i, wa[i], exp_a[i]);
      end
    end
    tests++;
    if (db.size() != 1 || db[0] != 0 || dn[0] != 1 || prim_count !== 3'd1) begin
      fails++;
      $display("FAIL abort_done: ndone=%0d cnt=%0d want 1 done base 0 cnt 1", db.size(), prim_count);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (ram[i] !== 32'hB0 + i) begin
        fails++;
        $display("FAIL abort_ram%0d: got %0h want %0h", i, ram[i], 32'hB0 + i);
      end
    end
    // accept coinciding with abort is dropped; next record starts at 4
    clear_logs();
    bus.in_valid = 1'b1;
    bus.in_data = 32'hD5;
    in_abort = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    in_abort = 1'b0;
    push(32'hD6);
    repeat (2) @(negedge clk);
    tests++;
    if (wa.size() != 1 || wa[0] != 4 || wd[0] != 32'hD6) begin
      fails++;
      $display("FAIL abort_accept: nwrites=%0d first=%0d/%0h want 1 write at 4 of d6",
               wa.size(), wa.size() > 0 ? wa[0] : -1, wd.size() > 0 ? wd[0] : -1);
    end
  endtask

  task automatic test_full();
    int n = 0;
    do_reset();
    for (int i = 0; i < 16; i++) push(32'hD0 + i);
    repeat (4) @(negedge clk);
    tests++;
    if (wa.size() != 16) begin
      fails++;
      $display("FAIL full_nwrites: got %0d want 16", wa.size());
    end
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      tests++;
      if (wa[i] != i) begin
        fails++;
        $display("FAIL full_addr%0d: got %0d want %0d", i, wa[i], i);
      end
    end
    tests++;
    if (db.size() != 4) begin
      fails++;
      $display("FAIL full_ndone: got %0d want 4", db.size());
    end
    for (int i = 0; i < 4 && i < db.size(); i++) begin
      tests++;
      if (db[i] != 4 * i || dn[i] != i + 1) begin
        fails++;
        $display("FAIL full_done%0d: base=%0d cnt=%0d want %0d %0d", i, db[i], dn[i], 4 * i, i + 1);
      end
    end
    tests++;
    if (full !== 1'b1 || bus.in_ready !== 1'b0 || prim_count !== 3'd4) begin
      fails++;
      $display("FAIL full_flags: full=%b rdy=%b cnt=%0d want 1 0 4", full, bus.in_ready, prim_count);
    end
    bus.in_valid = 1'b1;
    bus.in_data = 32'hEE;
    repeat (10) @(negedge clk);
    tests++;
    if (wa.size() != 16) begin
      fails++;
      $display("FAIL full_hold: got %0d writes want 16", wa.size());
    end
    // clear while full with a word offered
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if (prim_count !== 3'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL clear_state: cnt=%0d full=%b want 0 0", prim_count, full);
    end
    wait_ready();
    foreach (wd[i]) if (wd[i] == 32'hEE) n++;
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL clear_drop: got %0d writes of ee want 0", n);
    end
    clear_logs();
    push(32'h11);
    repeat (2) @(negedge clk);
    tests++;
    if (wa.size() != 1 || wa[0] != 0 || wd[0] != 32'h11) begin
      fails++;
      $display("FAIL clear_next: nwrites=%0d first=%0d want 1 write at 0", wa.size(),
               wa.size() > 0 ? wa[0] : -1);
    end
  endtask

  task automatic test_clear_run();
    int n = 0;
    do_reset();
    push(32'h21);
    clear_logs();
    bus.in_valid = 1'b1;
    bus.in_data = 32'h22;
    clear = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear = 1'b0;
    wait_ready();
    foreach (wd[i]) if (wd[i] == 32'h22) n++;
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL clear_beats_accept: got %0d writes of 22 want 0", n);
    end
    clear_logs();
    push(32'h33);
    repeat (2) @(negedge clk);
    tests++;
    if (wa.size() != 1 || wa[0] != 0) begin
      fails++;
      $display("FAIL clear_idx: nwrites=%0d first=%0d want 1 write at 0", wa.size(),
               wa.size() > 0 ? wa[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push(32'hE0 + i);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++;
    if (db.size() != 0) begin
      fails++;
      $display("FAIL midrst_nodone: got %0d dones want 0", db.size());
    end
    wait_ready();
    clear_logs();
    for (int i = 0; i < 4; i++) push(32'hF0 + i);
    repeat (4) @(negedge clk);
    tests++;
    if (wa.size() != 4 || wa[0] != 0 || db.size() != 1 || db[0] != 0) begin
      fails++;
      $display("FAIL midrst_next: nwrites=%0d ndone=%0d want 4 writes from 0 and done at 0",
               wa.size(), db.size());
    end
  endtask

`ifdef PRIM_RAM_WRITER_ZERO_FILL_EN
  task automatic test_zfill();
    int lo = 0;
    do_reset();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    while (bus.in_ready !== 1'b1 && lo < 40) begin
      lo++;
      @(negedge clk);
    end
    tests++;
    if (lo != 16) begin
      fails++;
      $display("FAIL zfill_len: in_ready low %0d cycles want 16", lo);
    end
    tests++;
    if (wa.size() != 16) begin
      fails++;
      $display("FAIL zfill_nwrites: got %0d want 16", wa.size());
    end
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      tests++;
      if (wa[i] != i || wd[i] != 0) begin
        fails++;
        $display("FAIL zfill_w%0d: addr=%0d data=%0h want %0d 0", i, wa[i], wd[i], i);
      end
    end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_record();
    test_abort();
    test_full();
    test_clear_run();
    test_reset_mid();
`ifdef PRIM_RAM_WRITER_ZERO_FILL_EN
    test_zfill();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
